c1_input_sched: RTL

- Controller-port scheduler in front of the C1 input read path. Produces the P1_IN/P2_IN words that the CPU reads through REG_P1CNT, REG_P2CNT and REG_STATUS_B.
- Synchronises up to four raw pads and, in multitap mode, selects which pad drives each port from the CPU-written REG_POUTPUT select bits.
- Applies a settle blanking window whenever a selection changes.
- Optionally freezes pad state once per frame so the CPU sees coherent snapshots.

---
 rtl/c1_io_pkg.sv | 19 +
 rtl/c1_port_settle.sv | 71 +++++++
 rtl/c1_input_sched.sv | 105 ++++++++++
 3 files changed

// File: rtl/c1_io_pkg.sv
// Shared types and constants for the C1 controller-port input path.
package c1_io_pkg;

    localparam int PAD_W = 10;

    typedef logic [PAD_W-1:0] pad_word_t;

    // Pads are active-low, so all-ones means nothing pressed.
    localparam pad_word_t PAD_RELEASED = 10'h3FF;

    localparam int POUT_P1_OFS = 0;
    localparam int POUT_P2_OFS = 3;

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } port_state_e;

endpackage

// File: rtl/c1_port_settle.sv
// One controller port: picks one of two pad sources and blanks the output
// for a fixed number of cycles whenever the selection changes.
module c1_port_settle
    import c1_io_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  pad_word_t  src0_i,
    input  pad_word_t  src1_i,
    input  logic       req_i,
    input  logic       req_vld_i,
    input  logic [7:0] settle_cyc_i,
    output pad_word_t  word_o,
    output logic       sel_o,
    output logic       busy_o
);

    port_state_e state_q;
    logic [7:0]  cnt_q;
    pad_word_t   word_q;
    logic        sel_q;
    logic        change;
    pad_word_t   selSrc;

    assign change = req_vld_i && (req_i != sel_q);
    assign selSrc = sel_q ? src1_i : src0_i;

    // A differing request always restarts the blanking window, even mid-settle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= STABLE;
            cnt_q   <= 8'd0;
            word_q  <= PAD_RELEASED;
            sel_q   <= 1'b0;
        end else begin
            case (state_q)
                STABLE: begin
                    if (change) begin
                        sel_q   <= req_i;
                        cnt_q   <= settle_cyc_i - 8'd1;
                        word_q  <= PAD_RELEASED;
                        state_q <= SETTLE;
                    end else begin
                        word_q  <= selSrc;
                    end
                end
                SETTLE: begin
                    word_q <= PAD_RELEASED;
                    if (change) begin
                        sel_q <= req_i;
                        cnt_q <= settle_cyc_i - 8'd1;
                    end else if (cnt_q == 8'd0) begin
                        state_q <= STABLE;
                        word_q  <= selSrc;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= STABLE;
                    word_q  <= PAD_RELEASED;
                end
            endcase
        end
    end

    assign word_o = word_q;
    assign sel_o  = sel_q;
    assign busy_o = (state_q == SETTLE);

endmodule

// File: rtl/c1_input_sched.sv
// Controller-port scheduler: synchronises four pads, optionally snapshots
// them per frame, and routes them through two settling port selectors.
module c1_input_sched
    import c1_io_pkg::*;
#(
    parameter int SETTLE_CYC     = 48,
    parameter bit LATCH_ON_FRAME = 1'b0
) (
    input  logic        CLK_24M,
    input  logic        RESET,
    input  logic [9:0]  PAD1_RAW,
    input  logic [9:0]  PAD2_RAW,
    input  logic [9:0]  PAD3_RAW,
    input  logic [9:0]  PAD4_RAW,
    input  logic        MULTITAP_EN,
    input  logic        POUT_WR,
    input  logic [5:0]  POUT_DATA,
    input  logic        FRAME_STB,
    output logic [9:0]  P1_IN,
    output logic [9:0]  P2_IN,
    output logic        P1_SEL,
    output logic        P2_SEL,
    output logic        BUSY
);

    localparam logic [7:0] SETTLE_LEN = 8'(SETTLE_CYC);

    pad_word_t raw [4];
    pad_word_t sync1_q [4];
    pad_word_t sync2_q [4];
    pad_word_t snap_q [4];
    pad_word_t src [4];

    logic req1, req2, reqVld;
    logic busy1, busy2;
    logic unused_pout;

    assign raw[0] = PAD1_RAW;
    assign raw[1] = PAD2_RAW;
    assign raw[2] = PAD3_RAW;
    assign raw[3] = PAD4_RAW;

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                sync1_q[i] <= PAD_RELEASED;
                sync2_q[i] <= PAD_RELEASED;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                sync1_q[i] <= raw[i];
                sync2_q[i] <= sync1_q[i];
            end
        end
    end

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) snap_q[i] <= PAD_RELEASED;
        end else if (FRAME_STB) begin
            for (int i = 0; i < 4; i++) snap_q[i] <= sync2_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) src[i] = LATCH_ON_FRAME ? snap_q[i] : sync2_q[i];
    end

    // With multitap off the request is held at 0 every cycle, so a port left
    // on pad3/pad4 falls back through a normal settle.
    assign req1   = POUT_DATA[POUT_P1_OFS] & MULTITAP_EN;
    assign req2   = POUT_DATA[POUT_P2_OFS] & MULTITAP_EN;
    assign reqVld = POUT_WR | ~MULTITAP_EN;

    assign unused_pout = ^{POUT_DATA[5:4], POUT_DATA[2:1]};

    c1_port_settle u_port1 (
        .clk_i        (CLK_24M),
        .rst_i        (RESET),
        .src0_i       (src[0]),
        .src1_i       (src[2]),
        .req_i        (req1),
        .req_vld_i    (reqVld),
        .settle_cyc_i (SETTLE_LEN),
        .word_o       (P1_IN),
        .sel_o        (P1_SEL),
        .busy_o       (busy1)
    );

    c1_port_settle u_port2 (
        .clk_i        (CLK_24M),
        .rst_i        (RESET),
        .src0_i       (src[1]),
        .src1_i       (src[3]),
        .req_i        (req2),
        .req_vld_i    (reqVld),
        .settle_cyc_i (SETTLE_LEN),
        .word_o       (P2_IN),
        .sel_o        (P2_SEL),
        .busy_o       (busy2)
    );

    assign BUSY = busy1 | busy2;

endmodule
